id_ex_hazard_ctrl: RTL
======================

# id_ex_hazard_ctrl

Pipeline hazard controller that drives the write-enable and bubble inputs of the IF/ID and ID/EX pipeline registers. It reads the state already captured in ID/EX (MemRead_EX, Instruction_EX, BranchTaken_EX) and the instruction currently decoding (Instruction_ID). From these it decides whether to stall fetch/decode, insert a bubble into ID/EX, or flush the wrong-path instruction in IF/ID. A small FSM holds multi-cycle load-use stalls for slow data memories. Optional performance counters record stall and flush cycles.

## Interface
Parameters:
- LOAD_STALL_CYCLES, 1, number of bubble cycles inserted per load-use hazard; legal range 1–4.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- Instruction_ID  in  32  instruction in ID; rs = [25:21], rt = [20:16].
- Instruction_EX  in  32  instruction held in ID/EX; rt = [20:16].
- MemRead_EX  in  1  ID/EX holds a load.
- BranchTaken_EX  in  1  branch in EX resolved taken this cycle.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID load enable.
- IDEXBubble  out  1  forces all ID/EX control fields to 0 on the next edge.
- IFIDFlush  out  1  loads zero (NOP) into IF/ID on the next edge.
- StallCount  out  32  load-stall cycles since reset; only counts when the perf-counter macro is defined.
- FlushCount  out  32  branch-flush cycles since reset; only counts when the perf-counter macro is defined.

## Operation
- Load hazard condition: load_hz = MemRead_EX & (rt_EX != 0) & ((rt_EX == rs_ID) | (rt_EX == rt_ID)).
- FSM states: RUN, STALL. There is also a 2-bit remaining-stall counter, cnt.
- Outputs are combinational from state and inputs. Default values: PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0.
- RUN, BranchTaken_EX=1:
  - IFIDFlush=1, IDEXBubble=1, PCWrite=1, IFIDWrite=1.
  - Stay in RUN.
  - The flush takes priority over load_hz.
- RUN, load_hz=1 and BranchTaken_EX=0:
  - PCWrite=0, IFIDWrite=0, IDEXBubble=1.
  - If LOAD_STALL_CYCLES>1: next state STALL, cnt ← LOAD_STALL_CYCLES−1.
  - Otherwise stay in RUN.
- STALL:
  - PCWrite=0, IFIDWrite=0, IDEXBubble=1.
  - cnt decrements each cycle; when cnt==1, next state is RUN with cnt ← 0.
  - load_hz is ignored in STALL.
- STALL, BranchTaken_EX=1 (not expected, because a bubble sits in EX):
  - Apply the RUN flush outputs.
  - Next state RUN, cnt ← 0.
- While rst is high:
  - PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=1.
  - State=RUN, cnt=0, StallCount=0, FlushCount=0.

## Timing
- Zero-cycle decision latency: outputs settle in the same cycle the inputs arrive and take effect on the next rising clk.
- Total bubbles per load-use hazard equal LOAD_STALL_CYCLES exactly. PCWrite is low for the same number of cycles.
- After the first bubble, MemRead_EX drops to 0. The FSM alone sustains the remaining stall cycles.
- A branch flush lasts one cycle and removes two wrong-path instructions: the one in IF/ID and the one entering ID/EX.
- When rst deasserts mid-stall, the block restarts in RUN with no residual stall.
- Counters saturate at 0xFFFFFFFF and never wrap.

## Configuration
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - StallCount increments every cycle that a load stall is active (RUN with load_hz, or STALL).
  - FlushCount increments every cycle with IFIDFlush=1 while rst is low.
- Undefined: both ports are tied to 32'h0 and no counter flops are built. All other behaviour is identical.

## Test plan
- Reset: assert rst asynchronously mid-cycle. The outputs immediately read PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=1, and both counters read 0.
- Load-use, LOAD_STALL_CYCLES=1:
  - Stimulus: EX holds lw $8 (MemRead_EX=1, rt_EX=8); ID holds add $9,$8,$10.
  - Required: exactly 1 cycle with PCWrite=0 and IDEXBubble=1; RUN on the next cycle; StallCount=1.
- Load-use, LOAD_STALL_CYCLES=3: same stimulus, with MemRead_EX dropping after the first edge. Required: exactly 3 consecutive bubble cycles, then PCWrite=1; StallCount=3.
- No false hazard:
  - Stimulus: MemRead_EX=1 with rt_EX=0 and rs_ID=0.
  - Required: no stall.
  - Stimulus: MemRead_EX=1 with rt_EX=5 while ID uses $6/$7.
  - Required: no stall.
- Branch vs load priority:
  - Stimulus: BranchTaken_EX=1 and load_hz=1 in the same cycle.
  - Required: IFIDFlush=1, IDEXBubble=1, PCWrite=1; state stays RUN; FlushCount=1, StallCount=0.
- Reset mid-stall: with LOAD_STALL_CYCLES=4, pulse rst in the second stall cycle. Required: after release, PCWrite=1 on the first cycle and the counters read 0.

Source files
------------

// File: rtl/id_ex_hazard_ctrl.sv
// rtl/id_ex_hazard_ctrl.sv - IF/ID and ID/EX hazard controller (load-use stall FSM, branch flush; optional counters via HAZARD_PERF_CNT_EN)
module id_ex_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instruction_ID,
    input  logic [31:0] Instruction_EX,
    input  logic        MemRead_EX,
    input  logic        BranchTaken_EX,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEXBubble,
    output logic        IFIDFlush,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
);

    // Remaining bubbles after the first one; legal range 1..4 keeps this in 2 bits.
    localparam logic [1:0] STALL_RELOAD = 2'(LOAD_STALL_CYCLES - 1);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic [4:0] rs_id, rt_id, rt_ex;
    logic       load_hz;

    assign rs_id = Instruction_ID[25:21];
    assign rt_id = Instruction_ID[20:16];
    assign rt_ex = Instruction_EX[20:16];

    // Only the register fields matter here; the remaining instruction bits are sunk.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{Instruction_ID[31:26], Instruction_ID[15:0],
                                 Instruction_EX[31:21], Instruction_EX[15:0]};

    // A load writing a non-zero register that the decoding instruction reads.
    assign load_hz = MemRead_EX && (rt_ex != 5'd0) &&
                     ((rt_ex == rs_id) || (rt_ex == rt_id));

    // State register and remaining-stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a taken branch always returns to RUN; STALL ignores new hazards.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (!BranchTaken_EX && load_hz && (LOAD_STALL_CYCLES > 1)) begin
                    state_d = STALL;
                    cnt_d   = STALL_RELOAD;
                end
            end
            STALL: begin
                if (BranchTaken_EX || (cnt_q == 2'd1)) begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Outputs: reset forces a NOP everywhere, flush beats stall, stall freezes fetch/decode.
    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXBubble = 1'b0;
        IFIDFlush  = 1'b0;
        if (rst) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
            IFIDFlush  = 1'b1;
        end else if (BranchTaken_EX) begin
            IDEXBubble = 1'b1;
            IFIDFlush  = 1'b1;
        end else if ((state_q == STALL) || load_hz) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic        stall_active, flush_active;
    logic [31:0] stall_cnt_q, flush_cnt_q;

    assign stall_active = !rst && !PCWrite;
    assign flush_active = !rst && IFIDFlush;

    // Saturating event counters; they stop at all-ones rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            if (stall_active && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'h1;
            if (flush_active && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'h1;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = 32'h0;
    assign FlushCount = 32'h0;
`endif

endmodule
